sng_par_lanes: RTL



---
 rtl/sc_pkg.sv | 27 ++
 rtl/sng_par_lanes_lane_cmp.sv | 19 +
 rtl/sng_par_lanes.sv | 107 ++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-number generator family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Number of advance steps needed to emit one full 2**width-bit stream.
    function automatic int steps(input int width, input int lanes);
        return (1 << width) / lanes;
    endfunction

endpackage

// File: rtl/sng_par_lanes_lane_cmp.sv
// One lane of the thermometer generator: lane_bit = (cnt + K) < val.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, sampled by the parent on a step.
// Ports: cnt/val are the stream position and latched operand, lane_bit the result.
module lane_cmp #(
    parameter int WIDTH = 5,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] val,
    output logic             lane_bit
);

    // One extra bit so cnt + K cannot wrap before the compare.
    localparam logic [WIDTH:0] K_OFF = (WIDTH + 1)'(K);

    assign lane_bit = (({1'b0, cnt} + K_OFF) < {1'b0, val});

endmodule

// File: rtl/sng_par_lanes.sv
// Multi-lane deterministic stochastic number generator: emits LANES thermometer bits per step.
// Latency: one cycle from a step (en & adv_in while running) to sn_out/sn_valid.
// Backpressure: adv_in gates stepping (tie high or chain from an upstream ctr_overflow); en=0 freezes all.
// Ports: clk/rst (async, active high); en, start, bin_in, adv_in in;
//        sn_out, sn_valid, ctr_overflow, zero_tail, busy, done out.
module sng_par_lanes
    import sc_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int LANES  = 4,
    parameter int REPEAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             adv_in,
    output logic [LANES-1:0] sn_out,
    output logic             sn_valid,
    output logic             ctr_overflow,
    output logic             zero_tail,
    output logic             busy,
    output logic             done
);

    localparam int               STEPS    = steps(WIDTH, LANES);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((STEPS - 1) * LANES);
    localparam logic [WIDTH-1:0] CNT_INC  = WIDTH'(LANES);

    sc_state_t        state;
    sc_state_t        state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] val;
    logic [LANES-1:0] lane_bit;
    logic             step;
    logic             last_step;
    logic             latch;

    assign step      = en & adv_in & (state == RUN);
    assign last_step = step & (cnt == CNT_LAST);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_cmp #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_lane_cmp (
            .cnt      (cnt),
            .val      (val),
            .lane_bit (lane_bit[k])
        );
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (en && start) begin
                    latch     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // start is deliberately ignored here: no mid-stream restart.
                if (last_step && (REPEAT == 0)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            val          <= '0;
            sn_out       <= '0;
            sn_valid     <= 1'b0;
            ctr_overflow <= 1'b0;
        end else begin
            sn_valid     <= step;
            ctr_overflow <= last_step;
            if (latch) begin
                val <= bin_in;
                cnt <= '0;
            end else if (step) begin
                // cnt wraps naturally at 2**WIDTH, which is the period boundary.
                cnt    <= cnt + CNT_INC;
                sn_out <= lane_bit;
            end
        end
    end

    assign zero_tail = sn_valid & ~|sn_out;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

endmodule
